rs_flop_bank: RTL and testbench

RS_FLOP_BANK -- requirements
Module: rs_flop_bank

---
 rtl/rs_pkg.sv | 35 +++
 rtl/rs_cell.sv | 58 +++++
 rtl/rs_flop_bank.sv | 74 +++++++
 tb/tb_rs_flop_bank.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// Shared definitions for the set/reset flop bank: conflict-rule encodings,
// the change-counter width and the per-channel next-state rule.
package rs_pkg;

    // S=R=1 conflict rules selected by the MODE parameter
    localparam int unsigned MODE_RDOM   = 0;  // reset dominates
    localparam int unsigned MODE_SDOM   = 1;  // set dominates
    localparam int unsigned MODE_HOLD   = 2;  // keep current state
    localparam int unsigned MODE_TOGGLE = 3;  // invert while conflict persists

    // Width of the saturating change counter
    localparam int CNT_W = 16;

    // Next state of one channel from its synchronised requests
    function automatic logic rs_next(input int unsigned mode, input logic s,
                                     input logic r, input logic q);
        logic nxt;
        nxt = q;
        case ({s, r})
            2'b10:   nxt = 1'b1;
            2'b01:   nxt = 1'b0;
            2'b11: begin
                case (mode)
                    MODE_RDOM:   nxt = 1'b0;
                    MODE_SDOM:   nxt = 1'b1;
                    MODE_TOGGLE: nxt = ~q;
                    default:     nxt = q;
                endcase
            end
            default: nxt = q;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/rs_cell.sv
// One set/reset channel: optional request synchroniser followed by the
// clocked RS state with the selected conflict rule.
module rs_cell
    import rs_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned MODE        = MODE_RDOM,
    parameter logic        INIT        = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic s,
    input  logic r,
    output logic q,
    output logic q_next,
    output logic s_q,
    output logic r_q
);

    if (SYNC_STAGES == 0) begin : g_nosync
        assign s_q = s;
        assign r_q = r;
    end else begin : g_sync
        logic [SYNC_STAGES-1:0] s_sync;
        logic [SYNC_STAGES-1:0] r_sync;

        // Shift the raw requests through the synchroniser chain
        always_ff @(posedge clk or negedge rst_n) begin
            // NOTE: synchroniser flops are cleared on reset so that a request
            // captured before reset can never surface after release.
            if (!rst_n) begin
                s_sync <= '0;
                r_sync <= '0;
            end else begin
                // NOTE: non-blocking assignments let every stage sample the
                // previous stage's old value, forming a true shift chain.
                s_sync[0] <= s;
                r_sync[0] <= r;
                for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                    s_sync[i] <= s_sync[i-1];
                    r_sync[i] <= r_sync[i-1];
                end
            end
        end

        assign s_q = s_sync[SYNC_STAGES-1];
        assign r_q = r_sync[SYNC_STAGES-1];
    end

    assign q_next = rs_next(MODE, s_q, r_q, q);

    // Channel state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= INIT;
        else        q <= q_next;
    end

endmodule

// File: rtl/rs_flop_bank.sv
// Bank of WIDTH independent set/reset channels with a sticky conflict flag
// and a saturating count of cycles in which any channel changed.
module rs_flop_bank
    import rs_pkg::*;
#(
    parameter int unsigned      WIDTH       = 8,
    parameter int unsigned      SYNC_STAGES = 2,
    parameter int unsigned      MODE        = MODE_RDOM,
    parameter logic [WIDTH-1:0] INIT        = '0
) (
    input  logic             Clk,
    input  logic             Resetn,
    input  logic [WIDTH-1:0] S,
    input  logic [WIDTH-1:0] R,
    input  logic             ClearConflict,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn,
    output logic             Conflict,
    output logic [CNT_W-1:0] ChangeCount
);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("rs_flop_bank: WIDTH must be 1..32");
    end
    if (SYNC_STAGES > 3) begin : g_bad_sync
        $error("rs_flop_bank: SYNC_STAGES must be 0..3");
    end
    if (MODE > MODE_TOGGLE) begin : g_bad_mode
        $error("rs_flop_bank: MODE must be 0..3");
    end

    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] s_q;
    logic [WIDTH-1:0] r_q;
    logic             any_conflict;
    logic             changed;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        rs_cell #(
            .SYNC_STAGES(SYNC_STAGES),
            .MODE       (MODE),
            .INIT       (INIT[i])
        ) u_cell (
            .clk   (Clk),
            .rst_n (Resetn),
            .s     (S[i]),
            .r     (R[i]),
            .q     (Q[i]),
            .q_next(q_next[i]),
            .s_q   (s_q[i]),
            .r_q   (r_q[i])
        );
    end

    assign Qn           = ~Q;
    assign any_conflict = |(s_q & r_q);
    assign changed      = (q_next != Q);

    // Sticky conflict flag; a fresh conflict outranks a clear request
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) Conflict <= 1'b0;
        else         Conflict <= any_conflict | (Conflict & ~ClearConflict);
    end

    // Count cycles in which any channel changes, saturating at all-ones
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            ChangeCount <= '0;
        end else if (changed && (ChangeCount != '1)) begin
            ChangeCount <= ChangeCount + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_rs_flop_bank.sv
// Directed bench for rs_flop_bank: four instances (one per conflict MODE,
// INIT=0) plus one MODE 0 instance with INIT=8'hA5, all sharing stimulus.
module tb_rs_flop_bank;

    logic       Clk;
    logic       Resetn;
    logic [7:0] S;
    logic [7:0] R;
    logic       ClearConflict;

    logic [7:0]  q_m   [4];
    logic [7:0]  qn_m  [4];
    logic        conf_m[4];
    logic [15:0] cnt_m [4];

    logic [7:0]  q_i;
    logic [7:0]  qn_i;
    logic        conf_i;
    logic [15:0] cnt_i;

    int n_checks = 0;
    int n_fail   = 0;

    for (genvar m = 0; m < 4; m++) begin : g_mode
        rs_flop_bank #(
            .WIDTH(8), .SYNC_STAGES(2), .MODE(m), .INIT(8'h00)
        ) u_dut (
            .Clk          (Clk),
            .Resetn       (Resetn),
            .S            (S),
            .R            (R),
            .ClearConflict(ClearConflict),
            .Q            (q_m[m]),
            .Qn           (qn_m[m]),
            .Conflict     (conf_m[m]),
            .ChangeCount  (cnt_m[m])
        );
    end

    rs_flop_bank #(
        .WIDTH(8), .SYNC_STAGES(2), .MODE(0), .INIT(8'hA5)
    ) u_init (
        .Clk          (Clk),
        .Resetn       (Resetn),
        .S            (S),
        .R            (R),
        .ClearConflict(ClearConflict),
        .Q            (q_i),
        .Qn           (qn_i),
        .Conflict     (conf_i),
        .ChangeCount  (cnt_i)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Advance one rising edge and settle just past it
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Resetn        = 1'b0;
        S             = '0;
        R             = '0;
        ClearConflict = 1'b0;
        repeat (2) tick();
        Resetn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (q_i !== 8'hA5) begin n_fail++; $display("FAIL reset_q: got %h expected a5", q_i); end
        n_checks++;
        if (qn_i !== 8'h5A) begin n_fail++; $display("FAIL reset_qn: got %h expected 5a", qn_i); end
        n_checks++;
        if (conf_i !== 1'b0) begin n_fail++; $display("FAIL reset_conflict: got %b expected 0", conf_i); end
        n_checks++;
        if (cnt_i !== 16'h0000) begin n_fail++; $display("FAIL reset_count: got %h expected 0000", cnt_i); end
        for (int m = 0; m < 4; m++) begin
            n_checks++;
            if (q_m[m] !== 8'h00 || qn_m[m] !== 8'hFF) begin
                n_fail++;
                $display("FAIL reset_mode%0d_q: got q=%h qn=%h expected q=00 qn=ff", m, q_m[m], qn_m[m]);
            end
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (q_i !== 8'hA5 || cnt_i !== 16'h0000) begin
                n_fail++;
                $display("FAIL idle_after_reset edge %0d: got q=%h cnt=%h expected q=a5 cnt=0000", k + 1, q_i, cnt_i);
            end
        end
    endtask

    task automatic test_set_reset();
        do_reset();
        S = 8'h01;
        tick();                 // edge 1
        S = 8'h00;
        n_checks++;
        if (q_m[0] !== 8'h00) begin n_fail++; $display("FAIL set_latency e1: got %h expected 00", q_m[0]); end
        tick();                 // edge 2
        n_checks++;
        if (q_m[0] !== 8'h00) begin n_fail++; $display("FAIL set_latency e2: got %h expected 00", q_m[0]); end
        tick();                 // edge 3
        n_checks++;
        if (q_m[0] !== 8'h01 || qn_m[0] !== 8'hFE || cnt_m[0] !== 16'd1) begin
            n_fail++;
            $display("FAIL set_e3: got q=%h qn=%h cnt=%0d expected q=01 qn=fe cnt=1", q_m[0], qn_m[0], cnt_m[0]);
        end
        repeat (3) tick();
        R = 8'h01;
        tick();
        R = 8'h00;
        repeat (2) tick();
        for (int m = 0; m < 4; m++) begin
            n_checks++;
            if (q_m[m] !== 8'h00 || cnt_m[m] !== 16'd2) begin
                n_fail++;
                $display("FAIL reset_bit mode%0d: got q=%h cnt=%0d expected q=00 cnt=2", m, q_m[m], cnt_m[m]);
            end
        end
    endtask

    task automatic test_modes();
        logic [7:0]  exp_q  [4];
        logic [15:0] exp_cnt[4];
        do_reset();
        S = 8'h0F;
        R = 8'h0F;
        tick();                 // edge 1
        tick();                 // edge 2
        tick();                 // edge 3: first edge that sees s_q=r_q=1
        exp_q = '{8'h00, 8'h0F, 8'h00, 8'h0F};
        for (int m = 0; m < 4; m++) begin
            n_checks++;
            if (q_m[m] !== exp_q[m]) begin
                n_fail++;
                $display("FAIL conflict_e3 mode%0d: got %h expected %h", m, q_m[m], exp_q[m]);
            end
        end
        tick();                 // edge 4
        S = 8'h00;
        R = 8'h00;
        n_checks++;
        if (q_m[3] !== 8'h00) begin n_fail++; $display("FAIL toggle_e4: got %h expected 00", q_m[3]); end
        tick();                 // edge 5
        n_checks++;
        if (q_m[3] !== 8'h0F) begin n_fail++; $display("FAIL toggle_e5: got %h expected 0f", q_m[3]); end
        tick();                 // edge 6
        exp_q   = '{8'h00, 8'h0F, 8'h00, 8'h00};
        exp_cnt = '{16'd0, 16'd1, 16'd0, 16'd4};
        for (int m = 0; m < 4; m++) begin
            n_checks++;
            if (q_m[m] !== exp_q[m] || cnt_m[m] !== exp_cnt[m] || conf_m[m] !== 1'b1) begin
                n_fail++;
                $display("FAIL conflict_end mode%0d: got q=%h cnt=%0d conf=%b expected q=%h cnt=%0d conf=1",
                         m, q_m[m], cnt_m[m], conf_m[m], exp_q[m], exp_cnt[m]);
            end
        end
        repeat (2) tick();
        n_checks++;
        if (q_m[3] !== 8'h00 || cnt_m[3] !== 16'd4) begin
            n_fail++;
            $display("FAIL toggle_settled: got q=%h cnt=%0d expected q=00 cnt=4", q_m[3], cnt_m[3]);
        end
    endtask

    task automatic test_clear_conflict();
        // Conflict is still set from the previous scenario
        ClearConflict = 1'b1;
        tick();
        ClearConflict = 1'b0;
        for (int m = 0; m < 4; m++) begin
            n_checks++;
            if (conf_m[m] !== 1'b0) begin n_fail++; $display("FAIL clear mode%0d: got %b expected 0", m, conf_m[m]); end
        end
        S = 8'h80;
        R = 8'h80;
        tick();                 // edge 1
        tick();                 // edge 2: s_q=r_q=80 now visible
        n_checks++;
        if (conf_m[0] !== 1'b0) begin n_fail++; $display("FAIL conflict_early: got %b expected 0", conf_m[0]); end
        tick();                 // edge 3
        n_checks++;
        if (conf_m[0] !== 1'b1) begin n_fail++; $display("FAIL conflict_set: got %b expected 1", conf_m[0]); end
        ClearConflict = 1'b1;
        tick();                 // edge 4: clear while conflict is live
        S = 8'h00;
        R = 8'h00;
        n_checks++;
        if (conf_m[0] !== 1'b1) begin n_fail++; $display("FAIL clear_vs_new: got %b expected 1", conf_m[0]); end
        tick();                 // edge 5
        tick();                 // edge 6: last edge that still sees s_q&r_q
        n_checks++;
        if (conf_m[2] !== 1'b1) begin n_fail++; $display("FAIL clear_vs_tail: got %b expected 1", conf_m[2]); end
        tick();                 // edge 7: pipeline drained, clear takes effect
        ClearConflict = 1'b0;
        n_checks++;
        if (conf_m[2] !== 1'b0) begin n_fail++; $display("FAIL clear_after_drain: got %b expected 0", conf_m[2]); end
    endtask

    task automatic test_saturation();
        do_reset();
        S = 8'h01;
        R = 8'h01;
        // Toggling starts on edge 3, so after edge k the count is k-2
        repeat (1000) tick();
        n_checks++;
        if (cnt_m[3] !== 16'd998) begin n_fail++; $display("FAIL count_1000: got %0d expected 998", cnt_m[3]); end
        repeat (69000) tick();
        n_checks++;
        if (cnt_m[3] !== 16'hFFFF) begin n_fail++; $display("FAIL count_sat: got %h expected ffff", cnt_m[3]); end
        repeat (10) tick();
        n_checks++;
        if (cnt_m[3] !== 16'hFFFF) begin n_fail++; $display("FAIL count_hold: got %h expected ffff", cnt_m[3]); end
        n_checks++;
        if (cnt_m[0] !== 16'd0) begin n_fail++; $display("FAIL count_rdom: got %0d expected 0", cnt_m[0]); end
    endtask

    task automatic test_reset_midflight();
        S = 8'hFF;
        R = 8'h00;
        tick();                 // S=FF now sits in the first synchroniser stage
        Resetn = 1'b0;
        #2;
        n_checks++;
        if (q_i !== 8'hA5 || conf_i !== 1'b0 || cnt_m[3] !== 16'd0) begin
            n_fail++;
            $display("FAIL async_reset: got q=%h conf=%b cnt=%h expected q=a5 conf=0 cnt=0000", q_i, conf_i, cnt_m[3]);
        end
        S = 8'h00;
        repeat (2) tick();
        Resetn = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            n_checks++;
            if (q_i !== 8'hA5 || cnt_i !== 16'd0 || q_m[1] !== 8'h00 || cnt_m[1] !== 16'd0) begin
                n_fail++;
                $display("FAIL midflight edge %0d: got q_i=%h cnt_i=%0d q_m1=%h cnt_m1=%0d expected a5 0 00 0",
                         k + 1, q_i, cnt_i, q_m[1], cnt_m[1]);
            end
        end
    endtask

    initial begin
        Resetn        = 1'b0;
        S             = '0;
        R             = '0;
        ClearConflict = 1'b0;
        test_reset();
        test_set_reset();
        test_modes();
        test_clear_conflict();
        test_saturation();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
